// File: rtl/pkt_loader_if.sv
// ---------------------------------------------------------------------------
// pkt_loader_if
//   Byte stream handshake feeding the packet loader.
//   in_valid : producer has a byte on in_data / in_last
//   in_ready : consumer can take a byte this cycle
//   in_data  : packet byte
//   in_last  : final byte of the packet
// ---------------------------------------------------------------------------
interface pkt_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/pkt_loader.sv
// ---------------------------------------------------------------------------
// pkt_loader
//   Ingress packet writer. Packs a byte stream into big-endian 32-bit words,
//   writes them to the packet SRAM from byte address 0, then presents the
//   packet to the header parser and holds the buffer until it is released.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   in_s         byte stream (valid/ready, data, last)
//   sram_ce_o    SRAM chip enable (one cycle per word)
//   sram_we_o    SRAM write enable (mirrors ce)
//   sram_addr_o  word-aligned byte address
//   sram_sel_o   byte lanes, sel[3] = data[31:24]
//   sram_data_o  write data
//   pkt_valid_o  a complete packet sits in the SRAM
//   pkt_len_o    packet length in bytes (saturates at MAX_PKT_BYTES)
//   pkt_err_o    packet exceeded MAX_PKT_BYTES
//   pkt_done_i   parser releases the buffer
// ---------------------------------------------------------------------------
module pkt_loader #(
    parameter int MAX_PKT_BYTES = 2048
) (
    input  logic               clk,
    input  logic               rst,
    pkt_loader_if.slave        in_s,
    output logic               sram_ce_o,
    output logic               sram_we_o,
    output logic [31:0]        sram_addr_o,
    output logic [3:0]         sram_sel_o,
    output logic [31:0]        sram_data_o,
    output logic               pkt_valid_o,
    output logic [15:0]        pkt_len_o,
    output logic               pkt_err_o,
    input  logic               pkt_done_i
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);

    typedef enum logic [1:0] {RECV, FLUSH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [1:0]  lane_q,  lane_d;
    logic [31:0] pack_q,  pack_d;
    logic        err_q,   err_d;
    logic        ce_q,    ce_d;
    logic [31:0] addr_q,  addr_d;
    logic [3:0]  sel_q,   sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= MAX_LEN) ? MAX_LEN : v + 16'd1;
    endfunction

    // Lanes filled so far, left-aligned, given the lane of the newest byte.
    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b1000;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    // Lane 0 is the most significant byte.
    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        return word | ({b, 24'h0} >> {lane, 3'b000});
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RECV;
            cnt_q   <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
            err_q   <= 1'b0;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
            ce_q    <= ce_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        pack_d  = pack_q;
        err_d   = err_q;
        ce_d    = 1'b0;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        merged  = place_byte(pack_q, lane_q, in_s.in_data);

        case (state_q)
            RECV: begin
                if (in_s.in_valid) begin
                    if (cnt_q < MAX_LEN) begin
                        // Word completes on lane 3 or on the last byte; a
                        // full word that is also last yields a single write.
                        if (lane_q == 2'd3 || in_s.in_last) begin
                            ce_d    = 1'b1;
                            addr_d  = {16'h0, cnt_q[15:2], 2'b00};
                            sel_d   = lane_sel(lane_q);
                            wdata_d = merged;
                            pack_d  = '0;
                            lane_d  = '0;
                        end else begin
                            pack_d  = merged;
                            lane_d  = lane_q + 2'd1;
                        end
                    end else begin
                        // Beyond capacity: swallow the byte, flag the packet.
                        err_d = 1'b1;
                    end
                    cnt_d = sat_inc(cnt_q);
                    if (in_s.in_last) state_d = FLUSH;
                end
            end
            FLUSH: state_d = HOLD;
            HOLD: begin
                if (pkt_done_i) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    lane_d  = '0;
                    pack_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = RECV;
        endcase
    end

    assign in_s.in_ready = (state_q == RECV);
    assign sram_ce_o     = ce_q;
    assign sram_we_o     = ce_q;
    assign sram_addr_o   = addr_q;
    assign sram_sel_o    = sel_q;
    assign sram_data_o   = wdata_q;
    assign pkt_valid_o   = (state_q == HOLD);
    assign pkt_len_o     = (state_q == HOLD) ? cnt_q : 16'h0;
    assign pkt_err_o     = (state_q == HOLD) && err_q;

endmodule

// File: tb/tb_pkt_loader.sv
module tb_pkt_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       in_last = 1'b0;
    logic       pkt_done = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    wr_t qa[$];
    wr_t qb[$];

    always #5 clk = ~clk;

    // DUT A: default capacity; DUT B: 16-byte capacity. Both see the same stimulus.
    pkt_loader_if ifa ();
    pkt_loader_if ifb ();
    assign ifa.in_valid = in_valid;
    assign ifa.in_data  = in_data;
    assign ifa.in_last  = in_last;
    assign ifb.in_valid = in_valid;
    assign ifb.in_data  = in_data;
    assign ifb.in_last  = in_last;

    logic        a_ce, a_we, a_valid, a_err;
    logic [31:0] a_addr, a_data;
    logic [3:0]  a_sel;
    logic [15:0] a_len;
    logic        b_ce, b_we, b_valid, b_err;
    logic [31:0] b_addr, b_data;
    logic [3:0]  b_sel;
    logic [15:0] b_len;

    pkt_loader #(.MAX_PKT_BYTES(2048)) dut_a (
        .clk(clk), .rst(rst), .in_s(ifa.slave),
        .sram_ce_o(a_ce), .sram_we_o(a_we), .sram_addr_o(a_addr),
        .sram_sel_o(a_sel), .sram_data_o(a_data),
        .pkt_valid_o(a_valid), .pkt_len_o(a_len), .pkt_err_o(a_err),
        .pkt_done_i(pkt_done)
    );

    pkt_loader #(.MAX_PKT_BYTES(16)) dut_b (
        .clk(clk), .rst(rst), .in_s(ifb.slave),
        .sram_ce_o(b_ce), .sram_we_o(b_we), .sram_addr_o(b_addr),
        .sram_sel_o(b_sel), .sram_data_o(b_data),
        .pkt_valid_o(b_valid), .pkt_len_o(b_len), .pkt_err_o(b_err),
        .pkt_done_i(pkt_done)
    );

    always @(posedge clk) begin
        if (a_ce && a_we) qa.push_back('{a_addr, a_sel, a_data});
        if (b_ce && b_we) qb.push_back('{b_addr, b_sel, b_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_wr(input string tag, input wr_t got,
                          input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data);
        chk({tag, ".addr"}, got.addr, addr);
        chk({tag, ".sel"},  {28'h0, got.sel}, {28'h0, sel});
        chk({tag, ".data"}, got.data, data);
    endtask

    function automatic wr_t qa_at(input int i);
        if (i < qa.size()) return qa[i];
        return '0;
    endfunction

    function automatic wr_t qb_at(input int i);
        if (i < qb.size()) return qb[i];
        return '0;
    endfunction

    // Bytes base+0..base+n-1; optional idle cycle after each byte.
    // Returns at the negedge following the final accepted byte.
    task automatic send_pkt(input int n, input bit gap, input bit with_last, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            in_last  = with_last && (i == n - 1);
            @(posedge clk);
            if (gap && i != n - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_buf();
        @(negedge clk);
        pkt_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pkt_done = 1'b0;
        chk("release.in_ready", {31'h0, ifa.in_ready}, 32'd1);
        chk("release.pkt_valid", {31'h0, a_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst.in_ready", {31'h0, ifa.in_ready}, 32'd1);
        chk("rst.ce", {31'h0, a_ce}, 32'd0);
        chk("rst.valid", {31'h0, a_valid}, 32'd0);
        chk("rst.len", {16'h0, a_len}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 60-byte packet, no gaps
        qa.delete(); qb.delete();
        send_pkt(60, 1'b0, 1'b1, 8'h00);
        chk("p60.in_ready_low", {31'h0, ifa.in_ready}, 32'd0);
        chk("p60.last_wr_ce", {31'h0, a_ce}, 32'd1);
        chk("p60.valid_not_yet", {31'h0, a_valid}, 32'd0);
        @(negedge clk);
        chk("p60.valid", {31'h0, a_valid}, 32'd1);
        chk("p60.ce_off", {31'h0, a_ce}, 32'd0);
        chk("p60.nwr", qa.size(), 32'd15);
        for (int w = 0; w < 15; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            chk_wr("p60.wr", qa_at(w), 32'(4 * w), 4'b1111,
                   {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
        end
        chk("p60.len", {16'h0, a_len}, 32'd60);
        chk("p60.err", {31'h0, a_err}, 32'd0);
        chk("p60.b_nwr", qb.size(), 32'd4);
        chk("p60.b_len", {16'h0, b_len}, 32'd16);
        chk("p60.b_err", {31'h0, b_err}, 32'd1);
        release_buf();

        // 5-byte packet: full word then a 1-byte tail written in FLUSH
        qa.delete(); qb.delete();
        send_pkt(5, 1'b0, 1'b1, 8'h00);
        chk("p5.flush_ce", {31'h0, a_ce}, 32'd1);
        chk("p5.flush_addr", a_addr, 32'd4);
        @(negedge clk);
        chk("p5.nwr", qa.size(), 32'd2);
        chk_wr("p5.wr0", qa_at(0), 32'd0, 4'b1111, 32'h00010203);
        chk_wr("p5.wr1", qa_at(1), 32'd4, 4'b1000, 32'h04000000);
        chk("p5.len", {16'h0, a_len}, 32'd5);
        release_buf();

        // 14-byte packet with idle cycles between bytes
        qa.delete(); qb.delete();
        send_pkt(14, 1'b1, 1'b1, 8'h00);
        @(negedge clk);
        chk("p14.nwr", qa.size(), 32'd4);
        chk_wr("p14.wr0", qa_at(0), 32'd0,  4'b1111, 32'h00010203);
        chk_wr("p14.wr2", qa_at(2), 32'd8,  4'b1111, 32'h08090A0B);
        chk_wr("p14.wr3", qa_at(3), 32'd12, 4'b1100, 32'h0C0D0000);
        chk("p14.len", {16'h0, a_len}, 32'd14);

        // HOLD ignores incoming bytes
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF;
            in_last  = 1'b1;
            chk("hold.in_ready", {31'h0, ifa.in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("hold.nwr", qa.size(), 32'd4);
        chk("hold.valid", {31'h0, a_valid}, 32'd1);
        chk("hold.len", {16'h0, a_len}, 32'd14);
        release_buf();

        qa.delete(); qb.delete();
        send_pkt(4, 1'b0, 1'b1, 8'h40);
        @(negedge clk);
        chk("p4.nwr", qa.size(), 32'd1);
        chk_wr("p4.wr0", qa_at(0), 32'd0, 4'b1111, 32'h40414243);
        chk("p4.len", {16'h0, a_len}, 32'd4);
        release_buf();

        // 20-byte packet into the 16-byte DUT
        qa.delete(); qb.delete();
        send_pkt(20, 1'b0, 1'b1, 8'h10);
        @(negedge clk);
        chk("ovf.nwr", qb.size(), 32'd4);
        chk_wr("ovf.wr0", qb_at(0), 32'd0,  4'b1111, 32'h10111213);
        chk_wr("ovf.wr3", qb_at(3), 32'd12, 4'b1111, 32'h1C1D1E1F);
        chk("ovf.len", {16'h0, b_len}, 32'd16);
        chk("ovf.err", {31'h0, b_err}, 32'd1);
        chk("ovf.a_len", {16'h0, a_len}, 32'd20);
        chk("ovf.a_err", {31'h0, a_err}, 32'd0);
        release_buf();
        chk("ovf.err_cleared", {31'h0, b_err}, 32'd0);

        // Reset while a write is on the bus: ce must drop asynchronously
        send_pkt(4, 1'b0, 1'b0, 8'h00);
        chk("rstw.ce_before", {31'h0, a_ce}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw.ce", {31'h0, a_ce}, 32'd0);
        chk("rstw.we", {31'h0, a_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset after 6 bytes of a packet
        send_pkt(6, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        #1;
        chk("rst6.ce", {31'h0, a_ce}, 32'd0);
        chk("rst6.valid", {31'h0, a_valid}, 32'd0);
        chk("rst6.in_ready", {31'h0, ifa.in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        qa.delete(); qb.delete();
        send_pkt(4, 1'b0, 1'b1, 8'hA0);
        @(negedge clk);
        chk("rst6.nwr", qa.size(), 32'd1);
        chk_wr("rst6.wr0", qa_at(0), 32'd0, 4'b1111, 32'hA0A1A2A3);
        chk("rst6.len", {16'h0, a_len}, 32'd4);
        release_buf();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d/%0d checks before time limit", n_pass, n_chk);
        $fatal(1);
    end

endmodule
